// File: rtl/stack_pkg.sv
// Shared constants for the stack datapath: ALU opcodes, command kinds,
// response codes and the execution FSM state encoding.
package stack_pkg;

    // ALU opcodes, shared with the ALU
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;

    // Command kinds
    localparam logic [1:0] CMD_PUSH  = 2'd0;
    localparam logic [1:0] CMD_POP   = 2'd1;
    localparam logic [1:0] CMD_EXEC  = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    // Response codes
    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    // Execution FSM states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_B = 3'd1,
        S_RD_A = 3'd2,
        S_CALC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // NOT is the only unary opcode; everything else legal takes two operands
    function automatic logic is_unary(input logic [3:0] op);
        return op == OP_NOT;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Operand stack storage: one synchronous write port and two asynchronous
// read ports (top / operand B, and operand A). Contents are not reset.
module stack_mem #(
    parameter int DATA_SIZE = 11,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [AW-1:0]        raddr_b,
    output logic [DATA_SIZE-1:0] rdata_b,
    input  logic [AW-1:0]        raddr_a,
    output logic [DATA_SIZE-1:0] rdata_a
);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Single write port, no reset on the array
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_b = mem[raddr_b];
    assign rdata_a = mem[raddr_a];

endmodule

// File: rtl/stack_exec.sv
// Stack-machine execution front end: holds the operand stack, handles
// PUSH/POP/EXEC/CLEAR commands and drives the external ALU for EXEC.
module stack_exec
    import stack_pkg::*;
#(
    parameter int DATA_SIZE = 11,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_kind,
    input  logic [3:0]               cmd_opcode,
    input  logic [DATA_SIZE-1:0]     cmd_data,
    output logic [3:0]               alu_opcode,
    output logic [DATA_SIZE-1:0]     alu_a,
    output logic [DATA_SIZE-1:0]     alu_b,
    input  logic [DATA_SIZE-1:0]     alu_out,
    output logic [DATA_SIZE-1:0]     top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     resp_valid,
    output logic [1:0]               err_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;

    state_t               state_reg, state_next;
    logic [SW-1:0]        sp_reg, sp_next;
    logic [1:0]           err_reg, err_next;
    logic                 unary_reg, unary_next;
    logic                 exec_reg, exec_next;
    logic [DATA_SIZE-1:0] result_reg;

    logic                 accept;
    logic                 op_load;
    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [SW-1:0]        sp_m1, sp_m2;
    logic [AW-1:0]        addr_b, addr_a;
    logic [DATA_SIZE-1:0] rd_b, rd_a;

    assign sp_m1  = sp_reg - SW'(1);
    assign sp_m2  = sp_reg - SW'(2);
    assign addr_b = sp_m1[AW-1:0];
    assign addr_a = sp_m2[AW-1:0];

    assign cmd_ready  = (state_reg == S_IDLE) && rst_n;
    assign accept     = cmd_valid && cmd_ready;
    assign resp_valid = (state_reg == S_DONE);
    assign err_code   = err_reg;
    assign depth      = sp_reg;
    assign empty      = (sp_reg == '0);
    assign full       = (sp_reg == SW'(DEPTH));
    assign top        = empty ? '0 : rd_b;

    stack_mem #(
        .DATA_SIZE(DATA_SIZE),
        .DEPTH    (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .raddr_b(addr_b),
        .rdata_b(rd_b),
        .raddr_a(addr_a),
        .rdata_a(rd_a)
    );

    // FSM and control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            sp_reg    <= '0;
            err_reg   <= ERR_OK;
            unary_reg <= 1'b0;
            exec_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
            err_reg   <= err_next;
            unary_reg <= unary_next;
            exec_reg  <= exec_next;
        end
    end

    // Next-state, stack pointer and memory write control
    always_comb begin
        state_next = state_reg;
        sp_next    = sp_reg;
        err_next   = err_reg;
        unary_next = unary_reg;
        exec_next  = exec_reg;
        op_load    = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = sp_reg[AW-1:0];
        mem_wdata  = cmd_data;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    err_next   = ERR_OK;
                    exec_next  = 1'b0;
                    state_next = S_DONE;
                    case (cmd_kind)
                        CMD_PUSH: begin
                            if (full) begin
                                err_next = ERR_OVERFLOW;
                            end else begin
                                mem_we  = 1'b1;
                                sp_next = sp_reg + SW'(1);
                            end
                        end
                        CMD_POP: begin
                            if (empty) err_next = ERR_UNDERFLOW;
                            else       sp_next  = sp_m1;
                        end
                        CMD_EXEC: begin
                            // Opcode legality is judged before operand count
                            if (cmd_opcode > OP_NOT) begin
                                err_next = ERR_ILLEGAL;
                            end else if (sp_reg < (is_unary(cmd_opcode) ? SW'(1) : SW'(2))) begin
                                err_next = ERR_UNDERFLOW;
                            end else begin
                                op_load    = 1'b1;
                                unary_next = is_unary(cmd_opcode);
                                exec_next  = 1'b1;
                                state_next = S_RD_B;
                            end
                        end
                        default: begin
                            sp_next = '0;
                        end
                    endcase
                end
            end
            S_RD_B:  state_next = unary_reg ? S_CALC : S_RD_A;
            S_RD_A:  state_next = S_CALC;
            S_CALC:  state_next = S_DONE;
            S_DONE: begin
                state_next = S_IDLE;
                if (exec_reg) begin
                    mem_we    = 1'b1;
                    mem_wdata = result_reg;
                    if (unary_reg) begin
                        mem_waddr = addr_b;
                    end else begin
                        mem_waddr = addr_a;
                        sp_next   = sp_m1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ALU operand/opcode registers and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            result_reg <= '0;
        end else begin
            if (op_load) begin
                alu_opcode <= cmd_opcode;
            end
            if (state_reg == S_RD_B) begin
                if (unary_reg) begin
                    alu_a <= rd_b;
                    alu_b <= '0;
                end else begin
                    alu_b <= rd_b;
                end
            end
            if (state_reg == S_RD_A) begin
                alu_a <= rd_a;
            end
            if (state_reg == S_CALC) begin
                result_reg <= alu_out;
            end
        end
    end

endmodule

// File: tb/tb_stack_exec.sv
// Directed testbench for stack_exec with a behavioural ALU attached.
module tb_stack_exec;
    import stack_pkg::*;

    localparam int DW = 11;
    localparam int DP = 16;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_kind;
    logic [3:0]    cmd_opcode;
    logic [DW-1:0] cmd_data;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] top;
    logic [4:0]    depth;
    logic          empty;
    logic          full;
    logic          resp_valid;
    logic [1:0]    err_code;

    int n_vec = 0;
    int n_err = 0;
    int cycle_cnt = 0;

    // Results captured by do_cmd for the test tasks to judge
    int            g_lat;
    int            g_accept_cycle;
    logic          g_ready_after;
    logic [1:0]    g_err;
    logic [4:0]    g_resp_depth;
    logic [DW-1:0] g_resp_top;
    logic [DW-1:0] g_calc_a;
    logic [DW-1:0] g_calc_b;

    stack_exec #(.DATA_SIZE(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_opcode(cmd_opcode),
        .cmd_data  (cmd_data),
        .alu_opcode(alu_opcode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .top       (top),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .resp_valid(resp_valid),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Behavioural ALU: NOT is logical negation of A; CMP gives 1 / 0 / all-ones
    always_comb begin
        alu_out = '0;
        case (alu_opcode)
            OP_ADD:  alu_out = alu_a + alu_b;
            OP_SUB:  alu_out = alu_a - alu_b;
            OP_MUL:  alu_out = alu_a * alu_b;
            OP_DIV:  alu_out = (alu_b == '0) ? '1 : alu_a / alu_b;
            OP_AND:  alu_out = alu_a & alu_b;
            OP_NAND: alu_out = ~(alu_a & alu_b);
            OP_OR:   alu_out = alu_a | alu_b;
            OP_XOR:  alu_out = alu_a ^ alu_b;
            OP_CMP:  alu_out = (alu_a > alu_b) ? DW'(1) : ((alu_a == alu_b) ? '0 : '1);
            OP_NOT:  alu_out = (alu_a == '0) ? DW'(1) : '0;
            default: alu_out = '0;
        endcase
    end

    // Issue one command and wait for its response; leaves the bench one
    // cycle after resp_valid, with the FSM back in IDLE.
    task automatic do_cmd(input logic [1:0] kind, input logic [3:0] op, input logic [DW-1:0] data);
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!cmd_ready) begin
            n_err++;
            $display("FAIL ready_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid  = 1'b1;
        cmd_kind   = kind;
        cmd_opcode = op;
        cmd_data   = data;
        g_lat      = 0;
        g_calc_a   = '0;
        g_calc_b   = '0;
        do begin
            @(posedge clk);
            if (g_lat == 0) g_accept_cycle = cycle_cnt;
            #1;
            cmd_valid = 1'b0;
            g_lat++;
            if (g_lat == 1) g_ready_after = cmd_ready;
            if (g_lat == 3) begin
                g_calc_a = alu_a;
                g_calc_b = alu_b;
            end
        end while (!resp_valid && g_lat < 12);
        if (!resp_valid) begin
            n_err++;
            $display("FAIL resp_timeout: resp_valid=%0b required 1", resp_valid);
        end
        g_err        = err_code;
        g_resp_depth = depth;
        g_resp_top   = top;
        @(posedge clk); #1;
        $display("cmd kind=%0d op=%0d data=%0d -> err=%0d lat=%0d depth=%0d top=%0d",
                 kind, op, data, g_err, g_lat, depth, top);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_kind   = CMD_PUSH;
        cmd_opcode = OP_ADD;
        cmd_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (depth !== 5'd0) begin n_err++; $display("FAIL reset_depth: got %0d want 0", depth); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %0b want 1", empty); end
        n_vec++; if (top !== '0) begin n_err++; $display("FAIL reset_top: got %0d want 0", top); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low: got %0b want 0", cmd_ready); end
        n_vec++; if (resp_valid !== 1'b0 || err_code !== 2'd0) begin n_err++; $display("FAIL reset_resp: got %0b/%0d want 0/0", resp_valid, err_code); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %0b want 1", cmd_ready); end
        $display("reset sequence done");
    endtask

    task automatic test_add();
        int first_accept;
        do_cmd(CMD_PUSH, OP_ADD, 11'd10);
        first_accept = g_accept_cycle;
        n_vec++; if (g_lat != 1 || g_err !== ERR_OK) begin n_err++; $display("FAIL push_resp: lat %0d err %0d want 1/0", g_lat, g_err); end
        n_vec++; if (g_resp_depth !== 5'd1 || g_resp_top !== 11'd10) begin n_err++; $display("FAIL push_resp_state: depth %0d top %0d want 1/10", g_resp_depth, g_resp_top); end
        n_vec++; if (g_ready_after !== 1'b0) begin n_err++; $display("FAIL ready_after_accept: got %0b want 0", g_ready_after); end
        do_cmd(CMD_PUSH, OP_ADD, 11'd20);
        n_vec++; if (g_accept_cycle - first_accept != 2) begin n_err++; $display("FAIL push_throughput: got %0d cycles want 2", g_accept_cycle - first_accept); end
        do_cmd(CMD_EXEC, OP_ADD, 11'd0);
        n_vec++; if (g_calc_a !== 11'd10 || g_calc_b !== 11'd20) begin n_err++; $display("FAIL add_operands: a %0d b %0d want 10/20", g_calc_a, g_calc_b); end
        n_vec++; if (g_lat != 4 || g_err !== ERR_OK) begin n_err++; $display("FAIL add_latency: lat %0d err %0d want 4/0", g_lat, g_err); end
        n_vec++; if (top !== 11'd30 || depth !== 5'd1) begin n_err++; $display("FAIL add_result: top %0d depth %0d want 30/1", top, depth); end
    endtask

    task automatic test_arith();
        do_cmd(CMD_CLEAR, OP_ADD, 11'd0);
        do_cmd(CMD_PUSH, OP_ADD, 11'd20);
        do_cmd(CMD_PUSH, OP_ADD, 11'd10);
        do_cmd(CMD_EXEC, OP_SUB, 11'd0);
        n_vec++; if (top !== 11'd10 || depth !== 5'd1) begin n_err++; $display("FAIL sub_result: top %0d depth %0d want 10/1", top, depth); end
        do_cmd(CMD_PUSH, OP_ADD, 11'd24);
        do_cmd(CMD_PUSH, OP_ADD, 11'd25);
        do_cmd(CMD_EXEC, OP_MUL, 11'd0);
        n_vec++; if (top !== 11'd600 || depth !== 5'd2) begin n_err++; $display("FAIL mul_result: top %0d depth %0d want 600/2", top, depth); end
        do_cmd(CMD_PUSH, OP_ADD, 11'd5);
        do_cmd(CMD_EXEC, OP_DIV, 11'd0);
        n_vec++; if (top !== 11'd120 || depth !== 5'd2) begin n_err++; $display("FAIL div_result: top %0d depth %0d want 120/2", top, depth); end
    endtask

    task automatic test_underflow();
        do_cmd(CMD_CLEAR, OP_ADD, 11'd0);
        do_cmd(CMD_EXEC, OP_NOT, 11'd0);
        n_vec++; if (g_err !== ERR_UNDERFLOW || g_lat != 1) begin n_err++; $display("FAIL not_empty: err %0d lat %0d want 1/1", g_err, g_lat); end
        do_cmd(CMD_PUSH, OP_ADD, 11'd7);
        do_cmd(CMD_EXEC, OP_ADD, 11'd0);
        n_vec++; if (g_err !== ERR_UNDERFLOW) begin n_err++; $display("FAIL add_one_operand: err %0d want 1", g_err); end
        n_vec++; if (top !== 11'd7 || depth !== 5'd1) begin n_err++; $display("FAIL add_one_operand_state: top %0d depth %0d want 7/1", top, depth); end
        do_cmd(CMD_EXEC, OP_NOT, 11'd0);
        n_vec++; if (g_lat != 3 || g_err !== ERR_OK) begin n_err++; $display("FAIL not_latency: lat %0d err %0d want 3/0", g_lat, g_err); end
        n_vec++; if (top !== 11'd0 || depth !== 5'd1) begin n_err++; $display("FAIL not_result: top %0d depth %0d want 0/1", top, depth); end
    endtask

    task automatic test_full();
        do_cmd(CMD_CLEAR, OP_ADD, 11'd0);
        for (int i = 1; i <= 16; i++) begin
            do_cmd(CMD_PUSH, OP_ADD, DW'(i));
            n_vec++; if (g_err !== ERR_OK) begin n_err++; $display("FAIL fill_push_%0d: err %0d want 0", i, g_err); end
        end
        n_vec++; if (full !== 1'b1 || top !== 11'd16) begin n_err++; $display("FAIL full_state: full %0b top %0d want 1/16", full, top); end
        do_cmd(CMD_PUSH, OP_ADD, 11'd99);
        n_vec++; if (g_err !== ERR_OVERFLOW || top !== 11'd16 || depth !== 5'd16) begin n_err++; $display("FAIL overflow: err %0d top %0d depth %0d want 2/16/16", g_err, top, depth); end
        do_cmd(CMD_POP, OP_ADD, 11'd0);
        n_vec++; if (g_resp_top !== 11'd15 || g_resp_depth !== 5'd15 || g_err !== ERR_OK) begin n_err++; $display("FAIL pop: top %0d depth %0d err %0d want 15/15/0", g_resp_top, g_resp_depth, g_err); end
    endtask

    task automatic test_illegal_clear();
        do_cmd(CMD_EXEC, 4'd12, 11'd0);
        n_vec++; if (g_err !== ERR_ILLEGAL || g_lat != 1) begin n_err++; $display("FAIL illegal: err %0d lat %0d want 3/1", g_err, g_lat); end
        n_vec++; if (top !== 11'd15 || depth !== 5'd15 || alu_opcode !== OP_NOT) begin n_err++; $display("FAIL illegal_state: top %0d depth %0d op %0d want 15/15/9", top, depth, alu_opcode); end
        do_cmd(CMD_CLEAR, OP_ADD, 11'd0);
        n_vec++; if (depth !== 5'd0 || empty !== 1'b1 || g_err !== ERR_OK || top !== '0) begin n_err++; $display("FAIL clear: depth %0d empty %0b err %0d top %0d want 0/1/0/0", depth, empty, g_err, top); end
    endtask

    task automatic test_reset_mid_exec();
        logic saw_resp;
        do_cmd(CMD_PUSH, OP_ADD, 11'd123);
        do_cmd(CMD_PUSH, OP_ADD, 11'd122);
        cmd_valid  = 1'b1;
        cmd_kind   = CMD_EXEC;
        cmd_opcode = OP_CMP;
        @(posedge clk); #1;   // accepted, now in RD_B
        cmd_valid = 1'b0;
        @(posedge clk); #1;   // now in RD_A
        rst_n = 1'b0;
        #1;
        n_vec++; if (depth !== 5'd0 || cmd_ready !== 1'b0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset: depth %0d ready %0b resp %0b want 0/0/0", depth, cmd_ready, resp_valid); end
        n_vec++; if (alu_a !== '0 || alu_b !== '0 || alu_opcode !== 4'd0) begin n_err++; $display("FAIL mid_reset_alu: a %0d b %0d op %0d want 0/0/0", alu_a, alu_b, alu_opcode); end
        saw_resp = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1'b1;
        end
        n_vec++; if (saw_resp !== 1'b0) begin n_err++; $display("FAIL discarded_resp: got %0b want 0", saw_resp); end
        $display("reset asserted during EXEC CMP");
        do_cmd(CMD_PUSH, OP_ADD, 11'd4);
        n_vec++; if (g_err !== ERR_OK || top !== 11'd4 || depth !== 5'd1) begin n_err++; $display("FAIL push_after_reset: err %0d top %0d depth %0d want 0/4/1", g_err, top, depth); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_arith();
        test_underflow();
        test_full();
        test_illegal_clear();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
